// File: rtl/ravenoc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ravenoc_pkg
//  Description : Shared NoC types: flit type encoding, flit request/response
//                channel structs and width constants used by router stages.
//  Revision    : 1.0 - output stage types added
// ============================================================================
package ravenoc_pkg;

    // Flit geometry; the two MSBs of fdata carry the flit type
    localparam int FlitWidth   = 34;
    localparam int FlitTypeMsb = FlitWidth - 1;
    localparam int VcIdWidth   = 2;

    typedef enum logic [1:0] {
        HEAD      = 2'b00,
        BODY      = 2'b01,
        TAIL      = 2'b10,
        HEAD_TAIL = 2'b11
    } flit_type_t;

    typedef struct packed {
        logic [FlitWidth-1:0] fdata;
        logic                 valid;
        logic [VcIdWidth-1:0] vc_id;
    } s_flit_req_t;

    typedef struct packed {
        logic ready;
    } s_flit_resp_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter. Combinational grant searching from the
//                slot after the last winner; the pointer only moves to the
//                current winner when update_en_i is asserted.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [N-1:0]     req_i,
    input  logic             update_en_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             valid_o
);

    // Index of the most recent winner; reset so slot 0 is searched first
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] w_idx;

    // First requester found scanning ptr+1, ptr+2, ... wrapping at N
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        valid_o     = 1'b0;
        w_idx       = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = IDX_W'((int'(ptr_q) + k) % N);
            if (!valid_o && req_i[w_idx]) begin
                valid_o        = 1'b1;
                grant_idx_o    = w_idx;
                grant_o[w_idx] = 1'b1;
            end
        end
    end

    // Pointer follows the winner only when the grant is actually consumed
    always_ff @(posedge clk) begin
        if (arst) begin
            ptr_q <= IDX_W'(N - 1);
        end else if (update_en_i) begin
            ptr_q <= grant_idx_o;
        end
    end

endmodule
`default_nettype wire

// File: rtl/output_module.sv
`default_nettype none
// ============================================================================
//  Module      : output_module
//  Description : Router output stage. Round-robin arbitration among head
//                flits, wormhole lock held until the owner's tail passes,
//                and a 2-entry output FIFO toward the downstream hop.
//  Revision    : 1.0 - initial release
// ============================================================================
module output_module
    import ravenoc_pkg::*;
#(
    parameter int NUM_IN     = 4,
    parameter int FLIT_WIDTH = FlitWidth
) (
    input  logic              clk,
    input  logic              arst,
    input  s_flit_req_t       fin_req_i  [NUM_IN],
    input  logic [NUM_IN-1:0] port_req_i,
    output s_flit_resp_t      fin_resp_o [NUM_IN],
    output s_flit_req_t       fout_req_o,
    input  s_flit_resp_t      fout_resp_i,
    output logic              busy_o
);

    localparam int c_idx_w    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int c_type_msb = FLIT_WIDTH - 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    typedef struct packed {
        logic [FlitWidth-1:0] fdata;
        logic [VcIdWidth-1:0] vc_id;
    } buf_entry_t;

    // Arbitration / lock state
    state_t               state_q;
    logic [c_idx_w-1:0]   owner_q;
    logic                 busy_q;

    // Output FIFO storage
    buf_entry_t           buf_q [2];
    logic                 wr_ptr_q;
    logic                 rd_ptr_q;
    logic [1:0]           count_q;
    logic [1:0]           count_d;

    logic [NUM_IN-1:0]    w_cand;
    logic [NUM_IN-1:0]    w_arb_req;
    logic [NUM_IN-1:0]    w_grant;
    logic [c_idx_w-1:0]   w_grant_idx;
    logic                 w_arb_valid;
    logic                 w_arb_update;
    logic [NUM_IN-1:0]    w_ready;
    logic [c_idx_w-1:0]   w_sel_idx;
    s_flit_req_t          w_sel_req;
    flit_type_t           w_sel_type;
    logic                 w_has_space;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_lock_next;

    // An input competes only when it targets this port with a valid head flit
    always_comb begin
        w_cand = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_cand[i] = port_req_i[i] && fin_req_i[i].valid &&
                        ((flit_type_t'(fin_req_i[i].fdata[c_type_msb -: 2]) == HEAD) ||
                         (flit_type_t'(fin_req_i[i].fdata[c_type_msb -: 2]) == HEAD_TAIL));
        end
    end

    assign w_arb_req    = (state_q == ST_IDLE) ? w_cand : '0;
    assign w_arb_update = w_push && (state_q == ST_IDLE);

    rr_arbiter #(
        .N     (NUM_IN),
        .IDX_W (c_idx_w)
    ) u_rr_arbiter (
        .clk         (clk),
        .arst        (arst),
        .req_i       (w_arb_req),
        .update_en_i (w_arb_update),
        .grant_o     (w_grant),
        .grant_idx_o (w_grant_idx),
        .valid_o     (w_arb_valid)
    );

    assign w_has_space = (count_q < 2'd2);

    // Ready goes to the fresh winner in IDLE, or only to the owner while locked
    always_comb begin
        w_ready = '0;
        if (state_q == ST_IDLE) begin
            w_ready = w_grant & {NUM_IN{w_has_space && w_arb_valid}};
        end else begin
            w_ready[owner_q] = w_has_space && port_req_i[owner_q];
        end
    end

    assign w_sel_idx  = (state_q == ST_IDLE) ? w_grant_idx : owner_q;
    assign w_sel_req  = fin_req_i[w_sel_idx];
    assign w_sel_type = flit_type_t'(w_sel_req.fdata[c_type_msb -: 2]);
    assign w_push     = w_ready[w_sel_idx] && w_sel_req.valid;
    assign w_pop      = (count_q != 2'd0) && fout_resp_i.ready;
    assign count_d    = count_q + {1'b0, w_push} - {1'b0, w_pop};

    // Whether the wormhole lock will be held after this edge
    assign w_lock_next = (state_q == ST_IDLE) ? (w_push && (w_sel_type == HEAD))
                                              : !(w_push && (w_sel_type == TAIL));

    // Lock FSM: head opens the lock, owner's tail releases it; busy is registered
    always_ff @(posedge clk) begin
        if (arst) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_push && (w_sel_type == HEAD)) begin
                        state_q <= ST_LOCKED;
                        owner_q <= w_grant_idx;
                    end
                end
                ST_LOCKED: begin
                    if (w_push && (w_sel_type == TAIL)) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            busy_q <= w_lock_next || (count_d != 2'd0);
        end
    end

    // Two-entry FIFO; reset discards any buffered flits
    always_ff @(posedge clk) begin
        if (arst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else begin
            if (w_push) begin
                buf_q[wr_ptr_q] <= '{fdata: w_sel_req.fdata, vc_id: w_sel_req.vc_id};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    // Drive the downstream channel from the FIFO head entry
    always_comb begin
        fout_req_o       = '0;
        fout_req_o.valid = (count_q != 2'd0);
        fout_req_o.fdata = buf_q[rd_ptr_q].fdata;
        fout_req_o.vc_id = buf_q[rd_ptr_q].vc_id;
    end

    // Fan the ready vector out to the per-input response channels
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            fin_resp_o[i] = '{ready: w_ready[i]};
        end
    end

    assign busy_o = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_output_module.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_output_module
//  Description : Self-checking bench for output_module. Packets are queued per
//                input; a packet-level round-robin model predicts the flit
//                order seen downstream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_output_module;
    import ravenoc_pkg::*;

    localparam int NUM_IN = 4;

    logic              clk = 1'b0;
    logic              arst;
    s_flit_req_t       fin_req_i  [NUM_IN];
    logic [NUM_IN-1:0] port_req_i;
    s_flit_resp_t      fin_resp_o [NUM_IN];
    s_flit_req_t       fout_req_o;
    s_flit_resp_t      fout_resp_i;
    logic              busy_o;

    output_module #(
        .NUM_IN     (NUM_IN),
        .FLIT_WIDTH (FlitWidth)
    ) dut (
        .clk         (clk),
        .arst        (arst),
        .fin_req_i   (fin_req_i),
        .port_req_i  (port_req_i),
        .fin_resp_o  (fin_resp_o),
        .fout_req_o  (fout_req_o),
        .fout_resp_i (fout_resp_i),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cycle = 0;
    s_flit_req_t src_q [NUM_IN][$];
    s_flit_req_t exp_q [$];
    int          m_ptr;
    int          n_acc [NUM_IN];
    logic        ds_ready;
    bit          ds_rand;
    int          first_out;
    int          last_out;
    int          n_out;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    function automatic s_flit_req_t mk_flit(input flit_type_t t);
        s_flit_req_t f;
        f.fdata = {t, 32'($urandom)};
        f.valid = 1'b1;
        f.vc_id = 2'($urandom_range(0, 3));
        return f;
    endfunction

    function automatic bit is_last(input s_flit_req_t f);
        flit_type_t t;
        t = flit_type_t'(f.fdata[FlitTypeMsb -: 2]);
        return (t == TAIL) || (t == HEAD_TAIL);
    endfunction

    function automatic void add_packet(input int i, input int len);
        if (len == 1) begin
            src_q[i].push_back(mk_flit(HEAD_TAIL));
        end else begin
            src_q[i].push_back(mk_flit(HEAD));
            for (int b = 0; b < len - 2; b++) src_q[i].push_back(mk_flit(BODY));
            src_q[i].push_back(mk_flit(TAIL));
        end
    endfunction

    // Whole packets leave in round-robin order of the inputs that still hold packets
    function automatic void build_expected();
        s_flit_req_t cp [NUM_IN][$];
        s_flit_req_t f;
        int left;
        int pick;
        int c;
        left = 0;
        for (int i = 0; i < NUM_IN; i++) begin
            cp[i] = src_q[i];
            left += cp[i].size();
        end
        while (left > 0) begin
            pick = 0;
            for (int k = NUM_IN; k >= 1; k--) begin
                c = (m_ptr + k) % NUM_IN;
                if (cp[c].size() > 0) pick = c;
            end
            m_ptr = pick;
            do begin
                f = cp[pick].pop_front();
                exp_q.push_back(f);
                left--;
            end while (!is_last(f) && cp[pick].size() > 0);
        end
    endfunction

    function automatic logic [NUM_IN-1:0] ready_vec();
        logic [NUM_IN-1:0] v;
        for (int i = 0; i < NUM_IN; i++) v[i] = fin_resp_o[i].ready;
        return v;
    endfunction

    task automatic drive();
        for (int i = 0; i < NUM_IN; i++) begin
            if (src_q[i].size() > 0) begin
                fin_req_i[i]  = src_q[i][0];
                port_req_i[i] = 1'b1;
            end else begin
                fin_req_i[i]  = '0;
                port_req_i[i] = 1'b0;
            end
        end
        fout_resp_i.ready = ds_rand ? 1'($urandom_range(0, 1)) : ds_ready;
    endtask

    // One clock: observe handshakes mid-cycle, retire them after the edge
    task automatic step();
        bit acc [NUM_IN];
        bit fire;
        int nrdy;
        @(negedge clk);
        nrdy = 0;
        for (int i = 0; i < NUM_IN; i++) begin
            acc[i] = fin_resp_o[i].ready && fin_req_i[i].valid;
            nrdy += int'(fin_resp_o[i].ready);
        end
        check("ready_at_most_one", 64'(nrdy <= 1), 64'd1);
        fire = fout_req_o.valid && fout_resp_i.ready;
        if (fire) begin
            check("out_expected_avail", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0)
                check("out_flit", 64'({fout_req_o.vc_id, fout_req_o.fdata}),
                      64'({exp_q[0].vc_id, exp_q[0].fdata}));
            n_out++;
            if (first_out < 0) first_out = cycle;
            last_out = cycle;
        end
        @(posedge clk);
        cycle++;
        #1;
        for (int i = 0; i < NUM_IN; i++) begin
            if (acc[i]) begin
                void'(src_q[i].pop_front());
                n_acc[i]++;
            end
        end
        if (fire && exp_q.size() > 0) void'(exp_q.pop_front());
        drive();
    endtask

    function automatic int src_left();
        int s;
        s = 0;
        for (int i = 0; i < NUM_IN; i++) s += src_q[i].size();
        return s;
    endfunction

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || src_left() > 0) && n < 400) begin
            step();
            n++;
        end
        check({tag, "_exp_drained"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_src_drained"}, 64'(src_left()), 64'd0);
        check({tag, "_busy_idle"}, 64'(busy_o), 64'd0);
    endtask

    task automatic clear_acc();
        for (int i = 0; i < NUM_IN; i++) n_acc[i] = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        arst      = 1'b1;
        ds_ready  = 1'b1;
        ds_rand   = 1'b0;
        m_ptr     = NUM_IN - 1;
        first_out = -1;
        last_out  = -1;
        n_out     = 0;
        clear_acc();
        drive();
        repeat (2) @(posedge clk);
        #1;
        arst = 1'b0;

        // Idle after reset: nothing offered, nothing forwarded, not busy
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("rst_fout_valid", 64'(fout_req_o.valid), 64'd0);
            check("rst_readies", 64'(ready_vec()), 64'd0);
            check("rst_busy", 64'(busy_o), 64'd0);
        end
        @(posedge clk);
        cycle++;
        #1;

        // Two competing 3-flit packets: input 0 first, no interleaving
        add_packet(0, 3);
        add_packet(2, 3);
        build_expected();
        check("t2_first_owner_is_0", 64'(exp_q[0].fdata), 64'(src_q[0][0].fdata));
        drive();
        drain("t2");

        // Single-flit packets from every input: rotation and 1 flit/cycle
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NUM_IN; i++) add_packet(i, 1);
        build_expected();
        n_out     = 0;
        first_out = -1;
        drive();
        drain("t3");
        check("t3_out_count", 64'(n_out), 64'd8);
        check("t3_span_cycles", 64'(last_out - first_out + 1), 64'd8);

        // Downstream stall during a 5-flit packet
        clear_acc();
        ds_ready = 1'b0;
        add_packet(1, 5);
        build_expected();
        drive();
        repeat (6) step();
        check("t4_accepted_while_stalled", 64'(n_acc[1]), 64'd2);
        check("t4_owner_ready_low", 64'(fin_resp_o[1].ready), 64'd0);
        check("t4_fout_valid_held", 64'(fout_req_o.valid), 64'd1);
        check("t4_busy", 64'(busy_o), 64'd1);
        ds_ready = 1'b1;
        drive();
        drain("t4");
        check("t4_all_accepted", 64'(n_acc[1]), 64'd5);

        // BODY offered while IDLE is never accepted nor forwarded
        src_q[1].push_back(mk_flit(BODY));
        drive();
        for (int c = 0; c < 5; c++) begin
            step();
            check("t5_body_ready", 64'(fin_resp_o[1].ready), 64'd0);
            check("t5_fout_valid", 64'(fout_req_o.valid), 64'd0);
        end
        check("t5_busy", 64'(busy_o), 64'd0);
        src_q[1].delete();
        drive();

        // Reset after the 2nd flit of a 4-flit packet
        clear_acc();
        add_packet(0, 4);
        build_expected();
        drive();
        n = 0;
        while (n_acc[0] < 2 && n < 20) begin
            step();
            n++;
        end
        check("t6_two_accepted", 64'(n_acc[0]), 64'd2);
        arst = 1'b1;
        src_q[0].delete();
        exp_q.delete();
        m_ptr = NUM_IN - 1;
        drive();
        @(posedge clk);
        cycle++;
        #1;
        arst = 1'b0;
        check("t6_fout_valid_after_rst", 64'(fout_req_o.valid), 64'd0);
        check("t6_busy_after_rst", 64'(busy_o), 64'd0);
        check("t6_readies_after_rst", 64'(ready_vec()), 64'd0);
        src_q[3].push_back(mk_flit(HEAD_TAIL));
        build_expected();
        drive();
        step();
        check("t6_fresh_accepted", 64'(n_acc[3]), 64'd1);
        check("t6_fresh_valid", 64'(fout_req_o.valid), 64'd1);
        check("t6_fresh_data", 64'({fout_req_o.vc_id, fout_req_o.fdata}),
              64'({exp_q[0].vc_id, exp_q[0].fdata}));
        drain("t6");

        // Random packet mixes with random downstream back-pressure
        ds_rand = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                n = $urandom_range(0, 2);
                for (int p = 0; p < n; p++) add_packet(i, $urandom_range(1, 5));
            end
            build_expected();
            drive();
            drain("t7");
        end
        ds_rand = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
